// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into byte-wide instruction memory,
// big-endian, holding the CPU while a load session is in progress.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W+1:0] LIM =
    (ADDR_W+2)'(1) << ADDR_W;

  logic [1:0]        r_state;
  // one extra bit so a completely filled memory is distinguishable
  logic [ADDR_W:0]   r_ptr;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic              r_last;
  logic [ADDR_W-2:0] r_cnt;
  logic              r_ovf;

  logic [ADDR_W+1:0] w_ptr_n;
  logic              w_full;
  logic              w_we;
  logic [7:0]        w_byte;

  assign w_ptr_n = {1'b0, r_ptr} + (ADDR_W+2)'(4);
  assign w_full  = w_ptr_n > LIM;
  assign w_we    = (r_state == S_WRITE);

  always_comb begin
    w_byte = '0;
    unique case (r_idx)
      2'd0: w_byte = r_word[31:24];
      2'd1: w_byte = r_word[23:16];
      2'd2: w_byte = r_word[15:8];
      2'd3: w_byte = r_word[7:0];
      default: w_byte = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_ptr   <= (ADDR_W+1)'(BASE_ADDR);
            r_state <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (word_valid) begin
            if (w_full) begin
              r_ovf   <= 1'b1;
              r_state <= word_last ? S_DONE : S_ACCEPT;
            end else begin
              r_word  <= word_data;
              r_last  <= word_last;
              r_idx   <= '0;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_ptr   <= w_ptr_n[ADDR_W:0];
            r_cnt   <= r_cnt + 1'b1;
            r_state <= r_last ? S_DONE : S_ACCEPT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_ready = (r_state == S_ACCEPT);
  assign busy       = (r_state == S_ACCEPT) || w_we;
  assign cpu_hold   = busy;
  assign done       = (r_state == S_DONE);
  assign mem_we     = w_we;
  assign mem_addr   = w_we ?
    r_ptr[ADDR_W-1:0] + ADDR_W'(r_idx) : '0;
  assign mem_wdata  = w_we ? w_byte : '0;
  assign overflow   = r_ovf;
  assign word_count = r_cnt;

endmodule
